// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath select codes and the per-state control word.
`timescale 1ns/1ps

package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // aluOp codes are also decoded by the downstream ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
  } ctrl_t;

  // fetch marks the state whose irWrite/pcUpdate follow memReady
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALU;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_MEMDATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_fsm_instr_class_deco.sv
// Combinational opcode classifier used by the DECODE next-state logic.
`timescale 1ns/1ps

module instr_class_deco
  import main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic       is_mem,
  output logic       is_r,
  output logic       is_i,
  output logic       is_beq,
  output logic       is_jal,
  output logic       is_illegal
);

  always_comb begin
    is_mem     = 1'b0;
    is_r       = 1'b0;
    is_i       = 1'b0;
    is_beq     = 1'b0;
    is_jal     = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: is_mem     = 1'b1;
      OP_RTYPE:          is_r       = 1'b1;
      OP_ITYPE:          is_i       = 1'b1;
      OP_BRANCH:         is_beq     = 1'b1;
      OP_JAL:            is_jal     = 1'b1;
      default:           is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Main control FSM of the multicycle RV32I core with a memory-ready handshake.
`timescale 1ns/1ps

module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       memReady,
  output logic [1:0] aluOp,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcUpdate,
  output logic       branch,
  output logic       regWrite,
  output logic       memWrite,
  output logic       illegalOp,
  output logic [3:0] stateDbg
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   mem_ready;
  logic   is_mem;
  logic   is_r;
  logic   is_i;
  logic   is_beq;
  logic   is_jal;
  logic   is_illegal;

  assign mem_ready = MEM_WAIT ? memReady : 1'b1;

  instr_class_deco u_class (
    .op         (op),
    .is_mem     (is_mem),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_beq     (is_beq),
    .is_jal     (is_jal),
    .is_illegal (is_illegal)
  );

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem)      next_state = S_MEMADR;
        else if (is_r)   next_state = S_EXECR;
        else if (is_i)   next_state = S_EXECI;
        else if (is_beq) next_state = S_BEQ;
        else if (is_jal) next_state = S_JAL;
        else             next_state = S_FETCH;
      end
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so it always matches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ctrl_q <= ctrl_for(S_FETCH);
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_for(next_state);
    end
  end

  // Holding rst_n low forces every select and strobe to zero
  assign aluOp     = rst_n ? ctrl_q.alu_op     : 2'b00;
  assign aluSrcA   = rst_n ? ctrl_q.alu_src_a  : 2'b00;
  assign aluSrcB   = rst_n ? ctrl_q.alu_src_b  : 2'b00;
  assign resultSrc = rst_n ? ctrl_q.result_src : 2'b00;
  assign adrSrc    = rst_n & ctrl_q.adr_src;
  assign branch    = rst_n & ctrl_q.branch;
  assign regWrite  = rst_n & ctrl_q.reg_write;
  assign memWrite  = rst_n & ctrl_q.mem_write;
  assign irWrite   = rst_n & ctrl_q.fetch & mem_ready;
  assign pcUpdate  = rst_n & (ctrl_q.pc_update | (ctrl_q.fetch & mem_ready));
  assign illegalOp = rst_n & (state == S_DECODE) & is_illegal;
  assign stateDbg  = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: directed instruction sequences push expected
// per-cycle control vectors; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_main_fsm;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] SYS  = 7'b1110011;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       adr;
    logic       ir_w;
    logic       pc_u;
    logic       br;
    logic       reg_w;
    logic       mem_w;
    logic       ill;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       memReady;
  logic [1:0] aluOp;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] resultSrc;
  logic       adrSrc;
  logic       irWrite;
  logic       pcUpdate;
  logic       branch;
  logic       regWrite;
  logic       memWrite;
  logic       illegalOp;
  logic [3:0] stateDbg;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  main_fsm #(.MEM_WAIT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .memReady  (memReady),
    .aluOp     (aluOp),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .resultSrc (resultSrc),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .pcUpdate  (pcUpdate),
    .branch    (branch),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .illegalOp (illegalOp),
    .stateDbg  (stateDbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for one cycle, written straight from the state table
  function automatic obs_t expect_for(input logic [3:0] st, input logic rdy,
                                      input logic ill, input logic in_reset);
    obs_t e;
    e = '0;
    if (in_reset) return e;
    e.st = st;
    case (st)
      ST_FETCH:    begin e.src_b = 2'b10; e.res_src = 2'b10; e.ir_w = rdy; e.pc_u = rdy; end
      ST_DECODE:   begin e.src_a = 2'b01; e.src_b = 2'b01; e.ill = ill; end
      ST_MEMADR:   begin e.src_a = 2'b10; e.src_b = 2'b01; end
      ST_MEMREAD:  begin e.adr = 1'b1; end
      ST_MEMWB:    begin e.res_src = 2'b01; e.reg_w = 1'b1; end
      ST_MEMWRITE: begin e.adr = 1'b1; e.mem_w = 1'b1; end
      ST_EXECR:    begin e.src_a = 2'b10; e.alu_op = 2'b10; end
      ST_EXECI:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
      ST_ALUWB:    begin e.reg_w = 1'b1; end
      ST_BEQ:      begin e.src_a = 2'b10; e.alu_op = 2'b01; e.br = 1'b1; end
      ST_JAL:      begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_u = 1'b1; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  task automatic apply_stimulus(input logic [6:0] op_v, input logic rdy, input logic rst_v,
                                input logic [3:0] st, input logic ill, input string name);
    @(posedge clk);
    #1;
    op       = op_v;
    memReady = rdy;
    rst_n    = rst_v;
    exp_q.push_back(expect_for(st, rdy, ill, !rst_v));
    name_q.push_back(name);
  endtask

  task automatic step(input logic [6:0] op_v, input logic rdy, input logic [3:0] st,
                      input string name);
    apply_stimulus(op_v, rdy, 1'b1, st, 1'b0, name);
  endtask

  task automatic check_output();
    obs_t  want;
    obs_t  got;
    string tag;
    want = exp_q.pop_front();
    tag  = name_q.pop_front();
    got  = {stateDbg, aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc,
            irWrite, pcUpdate, branch, regWrite, memWrite, illegalOp};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
               tag, got.st, got[12:0], want.st, want[12:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output();
  end

  initial begin
    rst_n    = 1'b0;
    op       = ADD;
    memReady = 1'b0;

    for (int i = 0; i < 3; i++)
      apply_stimulus(ADD, 1'b1, 1'b0, ST_FETCH, 1'b0, "reset_hold");

    apply_stimulus(LW, 1'b1, 1'b1, ST_FETCH, 1'b0, "lw_fetch_after_release");
    step(LW, 1'b1, ST_DECODE,  "lw_decode");
    step(LW, 1'b1, ST_MEMADR,  "lw_memadr");
    step(LW, 1'b1, ST_MEMREAD, "lw_memread");
    step(LW, 1'b1, ST_MEMWB,   "lw_memwb");

    step(SW, 1'b0, ST_FETCH,    "sw_fetch_wait");
    step(SW, 1'b1, ST_FETCH,    "sw_fetch");
    step(SW, 1'b1, ST_DECODE,   "sw_decode");
    step(SW, 1'b1, ST_MEMADR,   "sw_memadr");
    step(SW, 1'b0, ST_MEMWRITE, "sw_memwrite_wait1");
    step(SW, 1'b0, ST_MEMWRITE, "sw_memwrite_wait2");
    step(SW, 1'b1, ST_MEMWRITE, "sw_memwrite_done");

    step(ADD, 1'b1, ST_FETCH,  "add_fetch");
    step(ADD, 1'b1, ST_DECODE, "add_decode");
    step(ADD, 1'b1, ST_EXECR,  "add_execr");
    step(ADD, 1'b1, ST_ALUWB,  "add_aluwb");
    step(BEQ, 1'b1, ST_FETCH,  "beq_fetch");
    step(BEQ, 1'b1, ST_DECODE, "beq_decode");
    step(BEQ, 1'b1, ST_BEQ,    "beq_branch");

    step(ADDI, 1'b1, ST_FETCH,  "addi_fetch");
    step(ADDI, 1'b1, ST_DECODE, "addi_decode");
    step(ADDI, 1'b1, ST_EXECI,  "addi_execi");
    step(ADDI, 1'b1, ST_ALUWB,  "addi_aluwb");

    step(JAL, 1'b1, ST_FETCH,  "jal_fetch");
    step(JAL, 1'b1, ST_DECODE, "jal_decode");
    step(JAL, 1'b1, ST_JAL,    "jal_jump");
    step(JAL, 1'b1, ST_ALUWB,  "jal_aluwb");

    step(SYS, 1'b1, ST_FETCH, "illegal_fetch");
    apply_stimulus(SYS, 1'b1, 1'b1, ST_DECODE, 1'b1, "illegal_decode");

    step(LW, 1'b1, ST_FETCH,   "illegal_then_fetch");
    step(LW, 1'b1, ST_DECODE,  "lw2_decode");
    step(LW, 1'b1, ST_MEMADR,  "lw2_memadr");
    step(LW, 1'b0, ST_MEMREAD, "lw2_memread_wait");
    apply_stimulus(LW, 1'b1, 1'b0, ST_FETCH, 1'b0, "reset_mid_memread");
    apply_stimulus(LW, 1'b1, 1'b0, ST_FETCH, 1'b0, "reset_mid_hold");
    apply_stimulus(ADD, 1'b1, 1'b1, ST_FETCH, 1'b0, "fetch_after_mid_reset");
    step(ADD, 1'b1, ST_DECODE, "add2_decode");
    step(ADD, 1'b1, ST_EXECR,  "add2_execr");
    step(ADD, 1'b1, ST_ALUWB,  "add2_aluwb");
    step(ADD, 1'b1, ST_FETCH,  "add2_next_fetch");

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
